display7_bank: RTL and testbench

Parametrised multi-digit seven-segment controller for the DE2 HEX display bank. It holds a registered NUM_DIGITS-nibble value loaded by strobe and decodes every digit in parallel to segment patterns. On top of plain decoding it adds leading-zero blanking, a decimal/hex mode and a free-running blink generator with per-digit blink mask. It sits between the counter datapath and the board's HEX pins, replacing per-digit decoder instances.

---
 rtl/display_pkg.sv | 35 +++
 rtl/seg7_decode.sv | 39 +++
 rtl/display7_bank.sv | 107 ++++++++++
 tb/tb_display7_bank.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display bank: digit/segment widths
// and the active-high segment patterns (bit order a(0)..g(6)).
package display_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    typedef logic [DIGIT_W-1:0] nibble_t;
    typedef logic [SEG_W-1:0]   seg_t;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_A     = 7'h77;
    localparam seg_t SEG_B     = 7'h7C;
    localparam seg_t SEG_C     = 7'h39;
    localparam seg_t SEG_D     = 7'h5E;
    localparam seg_t SEG_E     = 7'h79;
    localparam seg_t SEG_F     = 7'h71;
    localparam seg_t SEG_DASH  = 7'h40;
    localparam seg_t SEG_BLANK = 7'h00;

    // Convert an active-high pattern to the board's pin polarity.
    function automatic seg_t apply_polarity(input seg_t pattern, input logic active_low);
        apply_polarity = active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder; in decimal mode values above 9
// are shown as a dash.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] seg
);

    // Pattern lookup with decimal-mode dash override.
    always_comb begin
        seg = SEG_BLANK;
        if (!hex_mode && (nibble > 4'd9)) begin
            seg = SEG_DASH;
        end else begin
            case (nibble)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = SEG_A;
                4'hB: seg = SEG_B;
                4'hC: seg = SEG_C;
                4'hD: seg = SEG_D;
                4'hE: seg = SEG_E;
                4'hF: seg = SEG_F;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/display7_bank.sv
// Multi-digit seven-segment controller: registered value, parallel decode,
// leading-zero blanking, blink generator with per-digit mask, registered pins.
module display7_bank
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    iClk,
    input  logic                    iReset,
    input  logic                    iLoad,
    input  logic [4*NUM_DIGITS-1:0] iValue,
    input  logic                    iHexMode,
    input  logic                    iBlankLeadingZeros,
    input  logic                    iBlinkEnable,
    input  logic [NUM_DIGITS-1:0]   iBlinkMask,
    output logic [7*NUM_DIGITS-1:0] oDisplay,
    output logic                    oBlinkPhase
);

    localparam int                CNT_W     = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLINK_DIV - 1);
    localparam logic              POL_LOW   = (ACTIVE_LOW != 0);
    localparam seg_t              BLANK_OUT = apply_polarity(SEG_BLANK, POL_LOW);

    logic [4*NUM_DIGITS-1:0] value_r;
    logic [CNT_W-1:0]        blink_cnt_r;
    logic                    phase_r;
    logic [7*NUM_DIGITS-1:0] display_r;
    logic [7*NUM_DIGITS-1:0] display_next_s;
    logic [NUM_DIGITS-1:0]   lead_zero_s;
    seg_t                    seg_raw_s [NUM_DIGITS];

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dec
            seg7_decode u_dec (
                .nibble   (value_r[4*g +: 4]),
                .hex_mode (iHexMode),
                .seg      (seg_raw_s[g])
            );
        end
    endgenerate

    // Value capture register.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            value_r <= '0;
        end else if (iLoad) begin
            value_r <= iValue;
        end else begin
            value_r <= value_r;
        end
    end

    // Blink half-period counter and phase; cleared whenever blinking is disabled.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
        end else if (!iBlinkEnable) begin
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
        end else if (blink_cnt_r == CNT_LAST) begin
            blink_cnt_r <= '0;
            phase_r     <= ~phase_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + 1'b1;
            phase_r     <= phase_r;
        end
    end

    // Per-digit blanking priority: blink, then leading zero, then decoded pattern.
    always_comb begin : blank_logic
        logic all_zero_v;
        all_zero_v     = 1'b1;
        lead_zero_s    = '0;
        display_next_s = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero_v     = all_zero_v & (value_r[4*k +: 4] == 4'd0);
            lead_zero_s[k] = iBlankLeadingZeros & all_zero_v & (k != 0);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (phase_r && iBlinkMask[k]) begin
                display_next_s[7*k +: 7] = BLANK_OUT;
            end else if (lead_zero_s[k]) begin
                display_next_s[7*k +: 7] = BLANK_OUT;
            end else begin
                display_next_s[7*k +: 7] = apply_polarity(seg_raw_s[k], POL_LOW);
            end
        end
    end

    // Registered segment outputs; blank pattern during reset.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            display_r <= {NUM_DIGITS{BLANK_OUT}};
        end else begin
            display_r <= display_next_s;
        end
    end

    assign oDisplay    = display_r;
    assign oBlinkPhase = phase_r;

endmodule

// File: tb/tb_display7_bank.sv
// Directed bench for display7_bank (4 digits, BLINK_DIV=4, active-low pins).
module tb_display7_bank;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        hex_mode;
    logic        blz;
    logic        blink_en;
    logic [3:0]  blink_mask;
    logic [27:0] disp;
    logic        phase;

    int n_checks = 0;
    int n_fail   = 0;

    display7_bank #(
        .NUM_DIGITS (4),
        .BLINK_DIV  (4),
        .ACTIVE_LOW (1)
    ) dut (
        .iClk               (clk),
        .iReset             (rst),
        .iLoad              (load),
        .iValue             (value),
        .iHexMode           (hex_mode),
        .iBlankLeadingZeros (blz),
        .iBlinkEnable       (blink_en),
        .iBlinkMask         (blink_mask),
        .oDisplay           (disp),
        .oBlinkPhase        (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        int         cnt_m;
        logic       ph_m;
        logic       disp_ph_m;
        logic [6:0] d0_exp;

        rst        = 1'b1;
        load       = 1'b0;
        value      = 16'h0000;
        hex_mode   = 1'b1;
        blz        = 1'b0;
        blink_en   = 1'b0;
        blink_mask = 4'b0000;
        #12;
        check("reset_disp", disp, 28'hFFFFFFF);
        check("reset_phase", {27'd0, phase}, 28'd0);
        #1 rst = 1'b0;
        step();
        check("post_reset_0000", disp, {7'h40, 7'h40, 7'h40, 7'h40});

        // 0120 with leading-zero blanking, then without.
        load = 1'b1; value = 16'h0120; blz = 1'b1;
        step();
        load = 1'b0;
        step();
        check("lz_0120", disp, {7'h7F, 7'h79, 7'h24, 7'h40});
        blz = 1'b0;
        step();
        check("nolz_0120", disp, {7'h40, 7'h79, 7'h24, 7'h40});

        // All-zero value keeps a single 0.
        load = 1'b1; value = 16'h0000; blz = 1'b1;
        step();
        load = 1'b0;
        step();
        check("lz_0000", disp, {7'h7F, 7'h7F, 7'h7F, 7'h40});

        // Decimal vs hex mode.
        load = 1'b1; value = 16'hAB9F; blz = 1'b0; hex_mode = 1'b0;
        step();
        load = 1'b0;
        step();
        check("dec_AB9F", disp, {7'h3F, 7'h3F, 7'h10, 7'h3F});
        hex_mode = 1'b1;
        step();
        check("hex_AB9F", disp, {7'h08, 7'h03, 7'h10, 7'h0E});

        // Blinking digit 0 of 1234.
        load = 1'b1; value = 16'h1234; blink_mask = 4'b0001;
        step();
        load = 1'b0;
        step();
        check("steady_1234", disp, {7'h79, 7'h24, 7'h30, 7'h19});
        blink_en  = 1'b1;
        cnt_m     = 0;
        ph_m      = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            disp_ph_m = ph_m;
            if (cnt_m == 3) begin
                cnt_m = 0;
                ph_m  = ~ph_m;
            end else begin
                cnt_m = cnt_m + 1;
            end
            d0_exp = disp_ph_m ? 7'h7F : 7'h19;
            check("blink_phase", {27'd0, phase}, {27'd0, ph_m});
            check("blink_disp", disp, {7'h79, 7'h24, 7'h30, d0_exp});
        end
        // After 12 edges the phase has toggled three times: now in off phase.
        check("phase_after_12", {27'd0, phase}, 28'd1);
        blink_en = 1'b0;
        step();
        check("blink_off_phase", {27'd0, phase}, 28'd0);
        check("blink_off_disp_lag", disp, {7'h79, 7'h24, 7'h30, 7'h7F});
        step();
        check("blink_off_disp", disp, {7'h79, 7'h24, 7'h30, 7'h19});

        // Asynchronous reset mid-blink while loading.
        blink_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("pre_reset_phase", {27'd0, phase}, 28'd1);
        load = 1'b1; value = 16'h5555;
        #2 rst = 1'b1;
        #1;
        check("async_reset_disp", disp, 28'hFFFFFFF);
        check("async_reset_phase", {27'd0, phase}, 28'd0);
        step();
        check("held_reset_disp", disp, 28'hFFFFFFF);
        load = 1'b0;
        #2 rst = 1'b0;
        step();
        check("after_reset_disp", disp, {7'h40, 7'h40, 7'h40, 7'h40});
        check("after_reset_phase", {27'd0, phase}, 28'd0);
        for (int i = 0; i < 3; i++) step();
        check("restart_phase", {27'd0, phase}, 28'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
